// File: rtl/dmp_iteration_ctrl_if.sv
// Control/status bundle between the PageRank iteration sequencer and its surroundings.
// The sequencer takes the slave side of this interface. The environment driving it takes the master side.
interface dmp_iteration_ctrl_if #(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned ITER_W         = 16
);
  logic                      i_start;
  logic                      i_abort;
  logic [ITER_W-1:0]         i_max_iter;
  logic [NUM_HW_THREADS-1:0] i_thread_done;
  logic                      i_stream_done;
  logic                      i_apply_done;

  logic                      o_gather_go;
  logic                      o_next_iteration;
  logic [ITER_W-1:0]         o_iteration;
  logic                      o_busy;
  logic                      o_run_done;
  logic                      o_timeout_err;
  logic [NUM_HW_THREADS-1:0] o_missing_mask;

  modport master (
    output i_start, i_abort, i_max_iter, i_thread_done, i_stream_done, i_apply_done,
    input  o_gather_go, o_next_iteration, o_iteration, o_busy, o_run_done,
           o_timeout_err, o_missing_mask
  );

  modport slave (
    input  i_start, i_abort, i_max_iter, i_thread_done, i_stream_done, i_apply_done,
    output o_gather_go, o_next_iteration, o_iteration, o_busy, o_run_done,
           o_timeout_err, o_missing_mask
  );
endinterface

// File: rtl/dmp_iteration_ctrl.sv
// Deterministic PageRank iteration sequencer: gather -> serialize -> apply -> advance.
// The per-phase watchdog and the abort flush are handled here. Every output comes from a register.
module dmp_iteration_ctrl #(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned ITER_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  dmp_iteration_ctrl_if.slave io_bus
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W = ITER_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GATHER  = 3'd1,
    S_SERIAL  = 3'd2,
    S_APPLY   = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TMR_W-1:0]          r_timer;
  logic [TMR_W-1:0]          w_timer_nxt;
  logic [ITER_W-1:0]         r_limit;
  logic [ITER_W-1:0]         w_limit_nxt;
  logic [ITER_W-1:0]         r_iteration;
  logic [ITER_W-1:0]         w_iter_nxt;
  logic                      r_timeout_err;
  logic                      w_terr_nxt;
  logic [NUM_HW_THREADS-1:0] r_missing_mask;
  logic [NUM_HW_THREADS-1:0] w_mask_nxt;
  logic                      w_flush;
  logic                      w_expired;
  logic                      w_in_phase;
  logic [CNT_W-1:0]          w_iter_inc;
  logic [ITER_W-1:0]         w_iter_sat;

  logic                      r_gather_go;
  logic                      r_next_iteration;
  logic                      r_busy;
  logic                      r_run_done;

  // Completion test uses one extra bit so a limit of all-ones still matches.
  assign w_iter_inc = {1'b0, r_iteration} + CNT_W'(1);
  assign w_iter_sat = (&r_iteration) ? r_iteration : w_iter_inc[ITER_W-1:0];
  assign w_expired  = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_in_phase = (r_state == S_GATHER) || (r_state == S_SERIAL) || (r_state == S_APPLY);

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions; abort outranks every other event outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_limit_nxt = r_limit;
    w_iter_nxt  = r_iteration;
    w_terr_nxt  = r_timeout_err;
    w_mask_nxt  = r_missing_mask;
    w_flush     = 1'b0;
    w_timer_nxt = r_timer;

    if ((r_state != S_IDLE) && io_bus.i_abort) begin
      w_state_nxt = S_IDLE;
      w_flush     = 1'b1;
      w_terr_nxt  = 1'b0;
      w_mask_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_start && !io_bus.i_abort) begin
            w_limit_nxt = (io_bus.i_max_iter == '0) ? ITER_W'(1) : io_bus.i_max_iter;
            w_iter_nxt  = '0;
            w_terr_nxt  = 1'b0;
            w_mask_nxt  = '0;
            w_state_nxt = S_GATHER;
          end
        end
        S_GATHER: begin
          if (&io_bus.i_thread_done) begin
            w_state_nxt = S_SERIAL;
          end else if (w_expired) begin
            w_mask_nxt  = ~io_bus.i_thread_done;
            w_terr_nxt  = 1'b1;
            w_state_nxt = S_ERROR;
          end
        end
        S_SERIAL: begin
          if (io_bus.i_stream_done) begin
            w_state_nxt = S_APPLY;
          end else if (w_expired) begin
            w_terr_nxt  = 1'b1;
            w_state_nxt = S_ERROR;
          end
        end
        S_APPLY: begin
          if (io_bus.i_apply_done) begin
            w_state_nxt = S_ADVANCE;
          end else if (w_expired) begin
            w_terr_nxt  = 1'b1;
            w_state_nxt = S_ERROR;
          end
        end
        S_ADVANCE: begin
          w_iter_nxt  = w_iter_sat;
          w_state_nxt = (w_iter_inc == {1'b0, r_limit}) ? S_FINISH : S_GATHER;
        end
        S_FINISH: begin
          w_state_nxt = S_IDLE;
        end
        S_ERROR: begin
          w_state_nxt = S_ERROR;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // The watchdog restarts on every state change.
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if (w_in_phase) begin
      w_timer_nxt = r_timer + TMR_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_timer          <= '0;
      r_limit          <= '0;
      r_iteration      <= '0;
      r_timeout_err    <= 1'b0;
      r_missing_mask   <= '0;
      r_gather_go      <= 1'b0;
      r_next_iteration <= 1'b0;
      r_busy           <= 1'b0;
      r_run_done       <= 1'b0;
    end else begin
      r_timer          <= w_timer_nxt;
      r_limit          <= w_limit_nxt;
      r_iteration      <= w_iter_nxt;
      r_timeout_err    <= w_terr_nxt;
      r_missing_mask   <= w_mask_nxt;
      r_gather_go      <= (w_state_nxt == S_GATHER);
      r_next_iteration <= (w_state_nxt == S_ADVANCE) || w_flush;
      r_busy           <= (w_state_nxt != S_IDLE);
      r_run_done       <= (w_state_nxt == S_FINISH);
    end
  end

  assign io_bus.o_gather_go      = r_gather_go;
  assign io_bus.o_next_iteration = r_next_iteration;
  assign io_bus.o_iteration      = r_iteration;
  assign io_bus.o_busy           = r_busy;
  assign io_bus.o_run_done       = r_run_done;
  assign io_bus.o_timeout_err    = r_timeout_err;
  assign io_bus.o_missing_mask   = r_missing_mask;

endmodule

// File: tb/tb_dmp_iteration_ctrl.sv
// Bench for dmp_iteration_ctrl. Directed scenarios and random traffic are checked against a
// phase-level reference model that is advanced once per clock.
module tb_dmp_iteration_ctrl;

  localparam int unsigned NT  = 8;
  localparam int unsigned IW  = 4;
  localparam int unsigned TO  = 16;
  localparam int          MAXI = (1 << IW) - 1;

  localparam int PH_IDLE = 0, PH_GATHER = 1, PH_SERIAL = 2, PH_APPLY = 3,
                 PH_ADVANCE = 4, PH_FINISH = 5, PH_ERROR = 6;

  logic clk;
  logic rst_n;

  dmp_iteration_ctrl_if #(.NUM_HW_THREADS(NT), .ITER_W(IW)) bus ();

  dmp_iteration_ctrl #(
    .NUM_HW_THREADS(NT),
    .ITER_W        (IW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .io_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model
  int          m_ph;
  int          m_cyc;
  int          m_iter;
  int          m_limit;
  int          m_terr;
  logic [NT-1:0] m_mask;
  int          m_nit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_cyc = 0; m_iter = 0; m_limit = 0;
    m_terr = 0; m_mask = '0; m_nit = 0;
  endtask

  // Advance the model by one clock using the inputs presented for that edge.
  task automatic model_step();
    int prev;
    prev  = m_ph;
    m_nit = 0;
    if (m_ph == PH_IDLE) begin
      if (bus.i_start && !bus.i_abort) begin
        m_limit = (bus.i_max_iter == 0) ? 1 : int'(bus.i_max_iter);
        m_iter  = 0; m_terr = 0; m_mask = '0;
        m_ph    = PH_GATHER;
      end
    end else if (bus.i_abort) begin
      m_ph = PH_IDLE; m_nit = 1; m_terr = 0; m_mask = '0;
    end else begin
      case (m_ph)
        PH_GATHER:
          if (bus.i_thread_done == {NT{1'b1}}) m_ph = PH_SERIAL;
          else if (m_cyc + 1 == TO) begin
            m_mask = ~bus.i_thread_done; m_terr = 1; m_ph = PH_ERROR;
          end
        PH_SERIAL:
          if (bus.i_stream_done) m_ph = PH_APPLY;
          else if (m_cyc + 1 == TO) begin m_terr = 1; m_ph = PH_ERROR; end
        PH_APPLY:
          if (bus.i_apply_done) m_ph = PH_ADVANCE;
          else if (m_cyc + 1 == TO) begin m_terr = 1; m_ph = PH_ERROR; end
        PH_ADVANCE: begin
          if (m_iter < MAXI) m_iter = m_iter + 1;
          m_ph = (m_iter == m_limit) ? PH_FINISH : PH_GATHER;
        end
        PH_FINISH: m_ph = PH_IDLE;
        default: ;
      endcase
    end
    if (m_ph != prev) m_cyc = 0;
    else if (m_ph == PH_GATHER || m_ph == PH_SERIAL || m_ph == PH_APPLY) m_cyc = m_cyc + 1;
    if (m_ph == PH_ADVANCE) m_nit = 1;
  endtask

  task automatic compare_all();
    chk("gather_go",      32'(bus.o_gather_go),      32'(m_ph == PH_GATHER));
    chk("next_iteration", 32'(bus.o_next_iteration), 32'(m_nit));
    chk("iteration",      32'(bus.o_iteration),      32'(m_iter));
    chk("busy",           32'(bus.o_busy),           32'(m_ph != PH_IDLE));
    chk("run_done",       32'(bus.o_run_done),       32'(m_ph == PH_FINISH));
    chk("timeout_err",    32'(bus.o_timeout_err),    32'(m_terr));
    chk("missing_mask",   32'(bus.o_missing_mask),   32'(m_mask));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_thread_done = '0;
    bus.i_stream_done = 1'b0; bus.i_apply_done = 1'b0;
  endtask

  // Environment that completes each phase after a fixed number of cycles in it.
  task automatic drive_resp(input int gd, input int sd, input int ad);
    bus.i_start       = 1'b0;
    bus.i_abort       = 1'b0;
    bus.i_thread_done = (m_ph == PH_GATHER && m_cyc >= gd) ? {NT{1'b1}} : '0;
    bus.i_stream_done = (m_ph == PH_SERIAL && m_cyc >= sd);
    bus.i_apply_done  = (m_ph == PH_APPLY  && m_cyc >= ad);
  endtask

  task automatic run_auto(input int mi, input int gd, input int sd, input int ad,
                          output int nit, output int ndone);
    nit = 0; ndone = 0;
    idle_inputs();
    bus.i_max_iter = IW'(mi);
    bus.i_start    = 1'b1;
    cycle();
    for (int c = 0; c < 600; c++) begin
      drive_resp(gd, sd, ad);
      cycle();
      nit   += int'(bus.o_next_iteration);
      ndone += int'(bus.o_run_done);
      if (m_ph == PH_IDLE) break;
    end
    chk("run_end_busy", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int nit, ndone, k;
    bit hang;
    logic [NT-1:0] td;
    n_vec = 0; n_err = 0; hang = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.i_max_iter = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    cycle();

    // Three iterations with the nominal phase latencies
    run_auto(3, 2, 8, 1, nit, ndone);
    chk("t1_pulses", 32'(nit), 32'd3);
    chk("t1_run_done", 32'(ndone), 32'd1);
    chk("t1_iteration", 32'(bus.o_iteration), 32'd3);

    // A limit of zero behaves as one iteration
    run_auto(0, 1, 1, 0, nit, ndone);
    chk("t2_pulses", 32'(nit), 32'd1);
    chk("t2_iteration", 32'(bus.o_iteration), 32'd1);

    // All-ones limit runs to completion with the counter at all-ones
    run_auto(MAXI, 0, 0, 0, nit, ndone);
    chk("tsat_pulses", 32'(nit), 32'(MAXI));
    chk("tsat_iteration", 32'(bus.o_iteration), 32'(MAXI));
    chk("tsat_run_done", 32'(ndone), 32'd1);

    // Gather watchdog with one thread stuck
    idle_inputs();
    bus.i_max_iter = IW'(2); bus.i_start = 1'b1;
    cycle();
    bus.i_start = 1'b0; bus.i_thread_done = 8'b1011_1111;
    repeat (TO - 1) cycle();
    chk("t3_still_gather", 32'(bus.o_gather_go), 32'd1);
    cycle();
    chk("t3_error_busy", 32'(bus.o_busy), 32'd1);
    chk("t3_timeout_err", 32'(bus.o_timeout_err), 32'd1);
    chk("t3_missing_mask", 32'(bus.o_missing_mask), 32'h40);
    bus.i_start = 1'b1;
    cycle();
    chk("t3_start_ignored", 32'(bus.o_timeout_err), 32'd1);
    bus.i_start = 1'b0; bus.i_abort = 1'b1;
    cycle();
    chk("t3_abort_clear", 32'(bus.o_timeout_err), 32'd0);
    chk("t3_abort_idle", 32'(bus.o_busy), 32'd0);
    bus.i_abort = 1'b0;

    // Abort during SERIAL of the second iteration
    idle_inputs();
    bus.i_max_iter = IW'(3); bus.i_start = 1'b1;
    cycle();
    for (int c = 0; c < 100; c++) begin
      if (m_ph == PH_SERIAL && m_iter == 1) break;
      drive_resp(1, 2, 0);
      cycle();
    end
    idle_inputs();
    cycle();
    chk("t4_in_serial", 32'(bus.o_busy), 32'd1);
    bus.i_abort = 1'b1;
    cycle();
    chk("t4_flush", 32'(bus.o_next_iteration), 32'd1);
    chk("t4_idle", 32'(bus.o_busy), 32'd0);
    chk("t4_iter_frozen", 32'(bus.o_iteration), 32'd1);
    bus.i_abort = 1'b0;
    cycle();
    chk("t4_flush_single", 32'(bus.o_next_iteration), 32'd0);

    // start together with abort in IDLE does nothing
    bus.i_start = 1'b1; bus.i_abort = 1'b1; bus.i_max_iter = IW'(2);
    cycle();
    chk("t5_stay_idle", 32'(bus.o_busy), 32'd0);
    chk("t5_iter_kept", 32'(bus.o_iteration), 32'd1);
    bus.i_abort = 1'b0;
    cycle();
    bus.i_start = 1'b1;
    cycle();
    chk("t5_start_in_gather", 32'(bus.o_gather_go), 32'd1);
    bus.i_start = 1'b0;

    // Done bits high at different times never complete gather
    for (int j = 0; j < NT; j++) begin
      td = {NT{1'b1}};
      td[j] = 1'b0;
      bus.i_thread_done = td;
      cycle();
      chk("t6_no_serial", 32'(bus.o_gather_go), 32'd1);
    end
    bus.i_thread_done = {NT{1'b1}};
    cycle();
    chk("t6_serial_entry", 32'(bus.o_gather_go), 32'd0);
    idle_inputs();
    bus.i_abort = 1'b1;
    cycle();
    bus.i_abort = 1'b0;

    // Random traffic with occasional hung phases and one asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) hang = !hang;
      bus.i_start    = ($urandom_range(0, 7) == 0);
      bus.i_abort    = ($urandom_range(0, 79) == 0);
      bus.i_max_iter = IW'($urandom);
      if (hang) begin
        td = NT'($urandom);
        k  = $urandom_range(0, NT - 1);
        td[k] = 1'b0;
        bus.i_thread_done = td;
        bus.i_stream_done = 1'b0;
        bus.i_apply_done  = 1'b0;
      end else begin
        bus.i_thread_done = ($urandom_range(0, 2) == 0) ? {NT{1'b1}} : NT'($urandom);
        bus.i_stream_done = ($urandom_range(0, 3) == 0);
        bus.i_apply_done  = ($urandom_range(0, 2) == 0);
      end
      cycle();
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
